// File: rtl/deca_vip_nios2_gen2_cpu_ocimem_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus bundle for the OCI RAM arbiter.
//   Avalon debug memory slave signals (CPU side):
//     avalon_address, avalon_read, avalon_write, avalon_writedata  -> arbiter
//     avalon_readdata, avalon_waitrequest                          <- arbiter
//   OCI RAM port (registered RAM, read latency 1):
//     ram_addr, ram_wdata, ram_we                                  <- arbiter
//     ram_rdata                                                    -> arbiter
// modport slave  : the arbiter's view.
// modport master : the surrounding system's view (CPU + RAM).
// ---------------------------------------------------------------------------
interface deca_vip_nios2_gen2_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avalon_address;
  logic              avalon_read;
  logic              avalon_write;
  logic [31:0]       avalon_writedata;
  logic [31:0]       avalon_readdata;
  logic              avalon_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  modport slave (
    input  avalon_address, avalon_read, avalon_write, avalon_writedata,
    input  ram_rdata,
    output avalon_readdata, avalon_waitrequest,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output avalon_address, avalon_read, avalon_write, avalon_writedata,
    output ram_rdata,
    input  avalon_readdata, avalon_waitrequest,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/deca_vip_nios2_gen2_cpu_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// OCI RAM arbiter: shares the Nios II on-chip debug RAM between the JTAG
// debug slave action strobes and the CPU's Avalon debug memory port.
//
// Ports:
//   clk, reset_n              : system clock, asynchronous active-low reset
//   jdo[37:0]                 : JTAG data; [ADDR_W+16:17] address, [34:3] data
//   take_action_ocimem_a      : load JTAG address from jdo, clear error
//   take_no_action_ocimem_a   : JTAG read at current address, then increment
//   take_action_ocimem_b      : JTAG write of jdo[34:3], then increment
//   MonDReg[31:0]             : last JTAG read data
//   monitor_ready             : no JTAG access pending
//   monitor_error             : sticky overrun flag
//   bus (slave modport)       : Avalon slave signals and the OCI RAM port
//
// The JTAG side holds at most one pending op. In IDLE the arbiter grants
// JTAG first unless the previous grant was also JTAG and the CPU is waiting.
// ---------------------------------------------------------------------------
module deca_vip_nios2_gen2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  deca_vip_nios2_gen2_cpu_ocimem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_JRD  = 2'd1,
    S_CRD  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] jaddr_reg;
  logic              jwrite_reg;
  logic [31:0]       jwdata_reg;
  logic [31:0]       mon_dreg_reg;
  logic              ready_reg;
  logic              error_reg;
  logic              last_jtag_reg;

  logic jtag_req, cpu_req;
  logic grant_jtag, grant_cpu;
  logic jtag_done, jtag_capture;
  logic strobe_any, accept, overrun;

  // Bits of jdo that carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

  assign jtag_req = ~ready_reg;
  assign cpu_req  = bus.avalon_read | bus.avalon_write;

  // JTAG wins unless it also won last time and the CPU is waiting.
  assign grant_jtag = (state_reg == S_IDLE) && jtag_req && (!cpu_req || !last_jtag_reg);
  assign grant_cpu  = (state_reg == S_IDLE) && cpu_req && !grant_jtag;

  assign strobe_any = take_no_action_ocimem_a | take_action_ocimem_b;
  assign accept     = strobe_any && ready_reg;
  // A strobe into a busy slot, or simultaneous read+write strobes, is an overrun.
  assign overrun    = (strobe_any && !ready_reg) ||
                      (take_no_action_ocimem_a && take_action_ocimem_b);

  always_comb begin
    state_next             = state_reg;
    bus.ram_addr           = '0;
    bus.ram_wdata          = '0;
    bus.ram_we             = 1'b0;
    bus.avalon_waitrequest = 1'b1;
    bus.avalon_readdata    = '0;
    jtag_done              = 1'b0;
    jtag_capture           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (grant_jtag) begin
          bus.ram_addr = jaddr_reg;
          if (jwrite_reg) begin
            bus.ram_we    = 1'b1;
            bus.ram_wdata = jwdata_reg;
            jtag_done     = 1'b1;
          end else begin
            state_next = S_JRD;
          end
        end else if (grant_cpu) begin
          bus.ram_addr = bus.avalon_address;
          // Read+write together is handled as a write.
          if (bus.avalon_write) begin
            bus.ram_we             = 1'b1;
            bus.ram_wdata          = bus.avalon_writedata;
            bus.avalon_waitrequest = 1'b0;
          end else begin
            state_next = S_CRD;
          end
        end
      end
      S_JRD: begin
        jtag_done    = 1'b1;
        jtag_capture = 1'b1;
        state_next   = S_IDLE;
      end
      S_CRD: begin
        bus.avalon_readdata    = bus.ram_rdata;
        bus.avalon_waitrequest = 1'b0;
        state_next             = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      jaddr_reg     <= '0;
      jwrite_reg    <= 1'b0;
      jwdata_reg    <= '0;
      mon_dreg_reg  <= '0;
      ready_reg     <= 1'b1;
      error_reg     <= 1'b0;
      last_jtag_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Completion and acceptance are mutually exclusive: completion needs a
      // pending op, acceptance needs an empty slot.
      if (jtag_done) begin
        ready_reg <= 1'b1;
      end
      if (accept) begin
        ready_reg  <= 1'b0;
        jwrite_reg <= take_action_ocimem_b;
        jwdata_reg <= jdo[34:3];
      end

      // An explicit address load overrides the post-access increment.
      if (take_action_ocimem_a) begin
        jaddr_reg <= jdo[ADDR_W+16:17];
      end else if (jtag_done) begin
        jaddr_reg <= jaddr_reg + ADDR_W'(1);
      end

      if (jtag_capture) begin
        mon_dreg_reg <= bus.ram_rdata;
      end

      // A new overrun in the same cycle as the clear still registers.
      if (take_action_ocimem_a) begin
        error_reg <= 1'b0;
      end
      if (overrun) begin
        error_reg <= 1'b1;
      end

      if (grant_jtag) begin
        last_jtag_reg <= 1'b1;
      end else if (grant_cpu) begin
        last_jtag_reg <= 1'b0;
      end
    end
  end

  assign MonDReg       = mon_dreg_reg;
  assign monitor_ready = ready_reg;
  assign monitor_error = error_reg;

endmodule
